// File: rtl/fir_complex_decim.sv
// Complex-valued decimating FIR with runtime-loadable taps and a ring buffer
// that keeps accepting input while a MAC pass is in progress.
module fir_complex_decim #(
    parameter int unsigned TAPS        = 20,
    parameter int unsigned DECIMATION  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COEFF_WIDTH = 32,
    parameter int unsigned FRAC_BITS   = 10,
    parameter logic [TAPS-1:0][COEFF_WIDTH-1:0] REAL_INIT = (TAPS*COEFF_WIDTH)'(1 << FRAC_BITS),
    parameter logic [TAPS-1:0][COEFF_WIDTH-1:0] IMAG_INIT = '0
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [DATA_WIDTH-1:0]                     i_in,
    input  logic                                      i_empty,
    input  logic [DATA_WIDTH-1:0]                     q_in,
    input  logic                                      q_empty,
    output logic                                      i_rd_en,
    output logic                                      q_rd_en,
    output logic [DATA_WIDTH-1:0]                     real_out,
    output logic [DATA_WIDTH-1:0]                     imag_out,
    output logic                                      real_wr_en,
    output logic                                      imag_wr_en,
    input  logic                                      real_full,
    input  logic                                      imag_full,
    input  logic                                      coef_wr_en,
    input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] coef_addr,
    input  logic [COEFF_WIDTH-1:0]                    coef_real,
    input  logic [COEFF_WIDTH-1:0]                    coef_imag,
    output logic                                      coef_ready,
    output logic                                      sat
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CW    = COEFF_WIDTH;
    localparam int unsigned DEPTH = TAPS + DECIMATION;
    localparam int unsigned AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PTRW  = $clog2(DEPTH);
    localparam int unsigned CNTW  = $clog2(DECIMATION + 1);
    localparam int unsigned MW    = DW + CW;
    localparam int unsigned ACCW  = MW + $clog2(TAPS) + 2;

    typedef enum logic [1:0] {S_WAIT, S_MAC, S_OUT} state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]   ring_i [DEPTH];
    logic signed [DW-1:0]   ring_q [DEPTH];
    logic [PTRW-1:0]        wp, rd_ptr, wp_prev;
    logic [CNTW-1:0]        new_cnt;
    logic [AW-1:0]          k;
    logic [TAPS-1:0][CW-1:0] coef_re, coef_im;
    logic signed [ACCW-1:0] acc_re, acc_im, acc_re_nx, acc_im_nx;
    logic signed [MW-1:0]   p_rr, p_ii, p_ri, p_ir;
    logic signed [DW-1:0]   x_re, x_im, res_re, res_im;
    logic signed [CW-1:0]   c_re, c_im;
    logic [DW:0]            sc_re, sc_im;
    logic                   clip, accept, start, last_tap, out_go, coef_we;

    // Arithmetic shift, then clip to the signed output range; MSB flags a clip.
    function automatic logic [DW:0] scale_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> FRAC_BITS;
        if (s[ACCW-1:DW-1] == {(ACCW-DW+1){s[ACCW-1]}})
            return {1'b0, s[DW-1:0]};
        else
            return {1'b1, s[ACCW-1], {(DW-1){~s[ACCW-1]}}};
    endfunction

    assign accept   = !reset && !i_empty && !q_empty && (new_cnt < CNTW'(DECIMATION));
    assign start    = (state == S_WAIT) && (new_cnt == CNTW'(DECIMATION));
    assign last_tap = (k == AW'(TAPS - 1));
    assign out_go   = (state == S_OUT) && !real_full && !imag_full;
    assign coef_we  = (state == S_WAIT) && coef_wr_en && ({1'b0, coef_addr} < (AW+1)'(TAPS));
    assign wp_prev  = (wp == '0) ? PTRW'(DEPTH - 1) : wp - 1'b1;

    assign i_rd_en    = accept;
    assign q_rd_en    = accept;
    assign real_wr_en = out_go;
    assign imag_wr_en = out_go;
    assign real_out   = out_go ? res_re : '0;
    assign imag_out   = out_go ? res_im : '0;
    assign sat        = out_go && clip;
    assign coef_ready = (state == S_WAIT);

    // One complex tap per cycle at full product precision.
    assign x_re      = ring_i[rd_ptr];
    assign x_im      = ring_q[rd_ptr];
    assign c_re      = $signed(coef_re[k]);
    assign c_im      = $signed(coef_im[k]);
    assign p_rr      = MW'(c_re) * MW'(x_re);
    assign p_ii      = MW'(c_im) * MW'(x_im);
    assign p_ri      = MW'(c_re) * MW'(x_im);
    assign p_ir      = MW'(c_im) * MW'(x_re);
    assign acc_re_nx = acc_re + ACCW'(p_rr) - ACCW'(p_ii);
    assign acc_im_nx = acc_im + ACCW'(p_ri) + ACCW'(p_ir);
    assign sc_re     = scale_sat(acc_re_nx);
    assign sc_im     = scale_sat(acc_im_nx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_WAIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:  if (start)    state_nx = S_MAC;
            S_MAC:   if (last_tap) state_nx = S_OUT;
            S_OUT:   if (out_go)   state_nx = S_WAIT;
            default:               state_nx = S_WAIT;
        endcase
    end

    // Sample ring and input bookkeeping; runs in every state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                ring_i[n] <= '0;
                ring_q[n] <= '0;
            end
            wp      <= '0;
            new_cnt <= '0;
        end else begin
            if (accept) begin
                ring_i[wp] <= i_in;
                ring_q[wp] <= q_in;
                wp         <= (wp == PTRW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            new_cnt <= (start ? '0 : new_cnt) + CNTW'(accept);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coef_re <= REAL_INIT;
            coef_im <= IMAG_INIT;
            acc_re  <= '0;
            acc_im  <= '0;
            k       <= '0;
            rd_ptr  <= '0;
            res_re  <= '0;
            res_im  <= '0;
            clip    <= 1'b0;
        end else begin
            if (coef_we) begin
                coef_re[coef_addr] <= coef_real;
                coef_im[coef_addr] <= coef_imag;
            end
            if (start) begin
                rd_ptr <= wp_prev;
                k      <= '0;
                acc_re <= '0;
                acc_im <= '0;
            end else if (state == S_MAC) begin
                acc_re <= acc_re_nx;
                acc_im <= acc_im_nx;
                k      <= k + 1'b1;
                rd_ptr <= (rd_ptr == '0) ? PTRW'(DEPTH - 1) : rd_ptr - 1'b1;
                if (last_tap) begin
                    res_re <= sc_re[DW-1:0];
                    res_im <= sc_im[DW-1:0];
                    clip   <= sc_re[DW] | sc_im[DW];
                end
            end
        end
    end

endmodule
